// File: rtl/tetris_board.sv
// Tetris playfield storage (10x20) with two combinational read ports, one write port and a line-clear engine.
// Define TETRIS_BOARD_LINE_CLEAR_EN to build the row scan/collapse FSM; without it a clear request just acknowledges.
module tetris_board #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [3:0] board_rx,
    input  logic [4:0] board_ry,
    output logic       board_rdata,
    input  logic       board_we,
    input  logic [3:0] board_wx,
    input  logic [4:0] board_wy,
    input  logic       board_wdata,
    input  logic [3:0] vga_rx,
    input  logic [4:0] vga_ry,
    output logic       vga_rdata,
    input  logic       clear_req,
    output logic       clear_busy,
    output logic       clear_done,
    output logic [2:0] lines_cleared,
    output logic [7:0] total_lines
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SHIFT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [COLS-1:0] rows_q [ROWS];
    logic [COLS-1:0] rows_d [ROWS];
    logic            clear_done_q, clear_done_d;
    logic [2:0]      lines_q, lines_d;
    logic [7:0]      total_q, total_d;
    logic            wr_in_range;

`ifdef TETRIS_BOARD_LINE_CLEAR_EN
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    logic [4:0] scan_idx_q, scan_idx_d;
    logic [4:0] shift_idx_q, shift_idx_d;
    logic [2:0] pass_cnt_q, pass_cnt_d;
    logic [8:0] total_sum;
`endif

    // Out-of-range cells read as occupied so they behave as wall and floor.
    assign board_rdata = (32'(board_rx) >= COLS || 32'(board_ry) >= ROWS) ? 1'b1
                                                                          : rows_q[board_ry][board_rx];
    assign vga_rdata   = (32'(vga_rx) >= COLS || 32'(vga_ry) >= ROWS) ? 1'b1
                                                                      : rows_q[vga_ry][vga_rx];

    assign wr_in_range   = (32'(board_wx) < COLS) && (32'(board_wy) < ROWS);
    assign clear_busy    = (state_q != S_IDLE);
    assign clear_done    = clear_done_q;
    assign lines_cleared = lines_q;
    assign total_lines   = total_q;

    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        clear_done_d = 1'b0;
        lines_d      = lines_q;
        total_d      = total_q;
`ifdef TETRIS_BOARD_LINE_CLEAR_EN
        scan_idx_d   = scan_idx_q;
        shift_idx_d  = shift_idx_q;
        pass_cnt_d   = pass_cnt_q;
        total_sum    = {1'b0, total_q} + {6'b0, pass_cnt_q};
`endif

        // Game-logic writes only land while the engine is idle.
        if (board_we && wr_in_range && state_q == S_IDLE) begin
            rows_d[board_wy][board_wx] = board_wdata;
        end

        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
`ifdef TETRIS_BOARD_LINE_CLEAR_EN
                    state_d    = S_SCAN;
                    scan_idx_d = LAST_ROW;
                    pass_cnt_d = 3'd0;
`else
                    state_d      = S_DONE;
                    clear_done_d = 1'b1;
`endif
                end
            end
`ifdef TETRIS_BOARD_LINE_CLEAR_EN
            S_SCAN: begin
                if (&rows_q[scan_idx_q]) begin
                    shift_idx_d = scan_idx_q;
                    state_d     = S_SHIFT;
                end else if (scan_idx_q == 5'd0) begin
                    // Results are registered on entry so they are valid alongside clear_done.
                    state_d      = S_DONE;
                    clear_done_d = 1'b1;
                    lines_d      = pass_cnt_q;
                    total_d      = (total_sum > 9'd255) ? 8'hFF : total_sum[7:0];
                end else begin
                    scan_idx_d = scan_idx_q - 5'd1;
                end
            end
            S_SHIFT: begin
                if (shift_idx_q == 5'd0) begin
                    rows_d[0]  = '0;
                    pass_cnt_d = pass_cnt_q + 3'd1;
                    state_d    = S_SCAN;
                end else begin
                    rows_d[shift_idx_q] = rows_q[shift_idx_q - 5'd1];
                    shift_idx_d         = shift_idx_q - 5'd1;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            rows_q       <= '{default: '0};
            clear_done_q <= 1'b0;
            lines_q      <= 3'd0;
            total_q      <= 8'd0;
`ifdef TETRIS_BOARD_LINE_CLEAR_EN
            scan_idx_q   <= 5'd0;
            shift_idx_q  <= 5'd0;
            pass_cnt_q   <= 3'd0;
`endif
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            clear_done_q <= clear_done_d;
            lines_q      <= lines_d;
            total_q      <= total_d;
`ifdef TETRIS_BOARD_LINE_CLEAR_EN
            scan_idx_q   <= scan_idx_d;
            shift_idx_q  <= shift_idx_d;
            pass_cnt_q   <= pass_cnt_d;
`endif
        end
    end

endmodule
